rs_slot_pair: RTL and testbench

//  Two-entry reservation station: the receiving end of one dispatch RS-type port pair (complex, simple or fp).

---
 rtl/rs_slot_pair_if.sv | 39 +++
 rtl/rs_slot_pair.sv | 122 ++++++++++++
 tb/tb_rs_slot_pair.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_slot_pair_if.sv
`default_nettype none
// ============================================================================
//  Module   : rs_slot_pair_if
//  Brief    : Dispatch, CDB wakeup and issue signals of a two-entry RS.
//  Revision : 1.0 - initial release
// ============================================================================
interface rs_slot_pair_if #(
    parameter int DATA_W = 76,
    parameter int TAG_W  = 6
);
    logic              flush;
    logic [DATA_W-1:0] in0_data;
    logic              in0_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_valid;
    logic              empty_0;
    logic              empty_1;
    logic              cdb0_valid;
    logic [TAG_W-1:0]  cdb0_tag;
    logic              cdb1_valid;
    logic [TAG_W-1:0]  cdb1_tag;
    logic              issue_valid;
    logic [DATA_W-1:0] issue_data;
    logic              issue_ready;
    logic              overflow_err;

    modport master (
        output flush, in0_data, in0_valid, in1_data, in1_valid,
               cdb0_valid, cdb0_tag, cdb1_valid, cdb1_tag, issue_ready,
        input  empty_0, empty_1, issue_valid, issue_data, overflow_err
    );

    modport slave (
        input  flush, in0_data, in0_valid, in1_data, in1_valid,
               cdb0_valid, cdb0_tag, cdb1_valid, cdb1_tag, issue_ready,
        output empty_0, empty_1, issue_valid, issue_data, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/rs_slot_pair.sv
`default_nettype none
// ============================================================================
//  Module   : rs_slot_pair
//  Brief    : Two-entry reservation station with CDB wakeup and oldest-first
//             valid/ready issue.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_slot_pair #(
    parameter int DATA_W = 76,
    parameter int TAG_W  = 6
) (
    input wire logic        clk,
    input wire logic        rst_n,
    rs_slot_pair_if.slave   rs
);
    localparam int c_SRC2_RDY = TAG_W;
    localparam int c_SRC1_RDY = 2*TAG_W + 1;

    logic [1:0]             r_valid;
    logic [1:0][DATA_W-1:0] r_payload;
    logic                   r_old1;      // 1: entry 1 is the older entry
    logic                   r_lock;
    logic                   r_lock_sel;
    logic                   r_overflow;

    logic [1:0]             w_in_valid;
    logic [1:0][DATA_W-1:0] w_in_data;
    logic [1:0]             w_ready;
    logic [1:0]             w_wr;
    logic [1:0]             w_ovf;
    logic [1:0]             w_clr;
    logic [1:0][DATA_W-1:0] w_payload_nxt;
    logic                   w_sel;
    logic                   w_issue_valid;
    logic                   w_accept;

    assign w_in_valid = {rs.in1_valid, rs.in0_valid};
    assign w_in_data  = {rs.in1_data,  rs.in0_data};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_entry
            logic [DATA_W-1:0] w_base;
            logic [TAG_W-1:0]  w_t1;
            logic [TAG_W-1:0]  w_t2;
            logic              w_hit1;
            logic              w_hit2;

            assign w_ready[k] = r_valid[k] & r_payload[k][c_SRC1_RDY]
                                           & r_payload[k][c_SRC2_RDY];
            assign w_wr[k]    = w_in_valid[k] & ~r_valid[k];
            assign w_ovf[k]   = w_in_valid[k] &  r_valid[k];

            // Incoming payloads see this cycle's broadcasts too.
            assign w_base = w_wr[k] ? w_in_data[k] : r_payload[k];
            assign w_t1   = w_base[2*TAG_W:TAG_W+1];
            assign w_t2   = w_base[TAG_W-1:0];
            assign w_hit1 = (rs.cdb0_valid & (rs.cdb0_tag == w_t1))
                          | (rs.cdb1_valid & (rs.cdb1_tag == w_t1));
            assign w_hit2 = (rs.cdb0_valid & (rs.cdb0_tag == w_t2))
                          | (rs.cdb1_valid & (rs.cdb1_tag == w_t2));

            assign w_payload_nxt[k] = {w_base[DATA_W-1:c_SRC1_RDY+1],
                                       w_base[c_SRC1_RDY] | w_hit1,
                                       w_t1,
                                       w_base[c_SRC2_RDY] | w_hit2,
                                       w_t2};
        end
    endgenerate

    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (&w_ready) begin
            w_sel = r_old1;
        end else begin
            w_sel = w_ready[1];
        end
    end

    assign w_issue_valid = |w_ready;
    assign w_accept      = w_issue_valid & rs.issue_ready & ~rs.flush;
    assign w_clr         = {w_accept & w_sel, w_accept & ~w_sel};

    assign rs.issue_valid  = w_issue_valid;
    assign rs.issue_data   = w_issue_valid ? r_payload[w_sel] : '0;
    assign rs.empty_0      = ~r_valid[0];
    assign rs.empty_1      = ~r_valid[1];
    assign rs.overflow_err = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 2'b00;
            r_payload  <= '0;
            r_old1     <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_sel <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_payload <= w_payload_nxt;
            if (rs.flush) begin
                r_valid <= 2'b00;
                r_old1  <= 1'b0;
                r_lock  <= 1'b0;
            end else begin
                r_overflow <= r_overflow | (|w_ovf);
                r_valid    <= (r_valid & ~w_clr) | w_wr;
                r_lock     <= w_issue_valid & ~rs.issue_ready;
                r_lock_sel <= w_sel;
                // A newly written entry is younger than any resident one.
                if (&w_wr) begin
                    r_old1 <= 1'b0;
                end else if (w_wr[0]) begin
                    r_old1 <= r_valid[1];
                end else if (w_wr[1]) begin
                    r_old1 <= ~r_valid[0];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rs_slot_pair.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_slot_pair
//  Brief    : Directed scenarios plus random traffic against a sequence-number
//             reference model of the two-entry reservation station.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rs_slot_pair;
    localparam int DATA_W = 76;
    localparam int TAG_W  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_slot_pair_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
    rs_slot_pair #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus.slave)
    );

    // Reference model: entry order is tracked by a global write sequence number.
    logic [DATA_W-1:0] m_pay [2];
    bit                m_valid [2];
    int                m_seq [2];
    int                m_cnt;
    bit                m_lock;
    int                m_lock_sel;
    bit                m_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] mk_pay(input int t1, input bit r1,
                                                 input int t2, input bit r2);
        logic [DATA_W-1:0] p;
        p = DATA_W'({$urandom(), $urandom(), $urandom()});
        p[2*TAG_W+1]       = r1;
        p[2*TAG_W:TAG_W+1] = TAG_W'(t1);
        p[TAG_W]           = r2;
        p[TAG_W-1:0]       = TAG_W'(t2);
        return p;
    endfunction

    function automatic bit m_ready(input int k);
        return m_valid[k] && m_pay[k][2*TAG_W+1] && m_pay[k][TAG_W];
    endfunction

    function automatic int m_sel();
        if (m_lock) return m_lock_sel;
        if (m_ready(0) && m_ready(1)) return (m_seq[0] < m_seq[1]) ? 0 : 1;
        return m_ready(1) ? 1 : 0;
    endfunction

    function automatic bit cdb_hit(input logic [TAG_W-1:0] t);
        return (bus.cdb0_valid && bus.cdb0_tag == t) ||
               (bus.cdb1_valid && bus.cdb1_tag == t);
    endfunction

    function automatic logic [DATA_W-1:0] wake(input logic [DATA_W-1:0] p);
        logic [DATA_W-1:0] q;
        q = p;
        if (cdb_hit(p[2*TAG_W:TAG_W+1])) q[2*TAG_W+1] = 1'b1;
        if (cdb_hit(p[TAG_W-1:0]))       q[TAG_W]     = 1'b1;
        return q;
    endfunction

    task automatic idle();
        bus.flush       = 1'b0;
        bus.in0_valid   = 1'b0;
        bus.in1_valid   = 1'b0;
        bus.in0_data    = '0;
        bus.in1_data    = '0;
        bus.cdb0_valid  = 1'b0;
        bus.cdb0_tag    = '0;
        bus.cdb1_valid  = 1'b0;
        bus.cdb1_tag    = '0;
        bus.issue_ready = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_pay[k]   = '0;
            m_seq[k]   = 0;
        end
        m_cnt      = 0;
        m_lock     = 1'b0;
        m_lock_sel = 0;
        m_ovf      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Checks outputs against the model, then advances the model over one edge.
    task automatic step();
        bit                ev;
        int                sel;
        bit                in_v [2];
        logic [DATA_W-1:0] in_d [2];
        logic [DATA_W-1:0] n_pay [2];
        bit                n_valid [2];
        int                n_seq [2];
        #2;
        ev  = m_ready(0) || m_ready(1);
        sel = m_sel();
        chk("empty_0", DATA_W'(bus.empty_0), DATA_W'(!m_valid[0]));
        chk("empty_1", DATA_W'(bus.empty_1), DATA_W'(!m_valid[1]));
        chk("issue_valid", DATA_W'(bus.issue_valid), DATA_W'(ev));
        chk("issue_data", bus.issue_data, ev ? m_pay[sel] : '0);
        chk("overflow_err", DATA_W'(bus.overflow_err), DATA_W'(m_ovf));

        in_v[0] = bus.in0_valid; in_d[0] = bus.in0_data;
        in_v[1] = bus.in1_valid; in_d[1] = bus.in1_data;
        for (int k = 0; k < 2; k++) begin
            n_valid[k] = m_valid[k];
            n_seq[k]   = m_seq[k];
            n_pay[k]   = wake(m_pay[k]);
        end
        if (bus.flush) begin
            n_valid[0] = 1'b0;
            n_valid[1] = 1'b0;
            m_lock     = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (in_v[k] && m_valid[k]) m_ovf = 1'b1;
                if (in_v[k] && !m_valid[k]) begin
                    n_pay[k]   = wake(in_d[k]);
                    n_valid[k] = 1'b1;
                    n_seq[k]   = m_cnt;
                    m_cnt++;
                end
            end
            if (ev && bus.issue_ready) n_valid[sel] = 1'b0;
            m_lock     = ev && !bus.issue_ready;
            m_lock_sel = sel;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = n_valid[k];
            m_pay[k]   = n_pay[k];
            m_seq[k]   = n_seq[k];
        end
    endtask

    logic [DATA_W-1:0] pa, pb;

    initial begin
        idle();
        model_reset();
        do_reset();
        @(posedge clk); #1;

        // Reset state and single-entry write/issue/accept.
        step();
        pa = mk_pay(1, 1'b1, 2, 1'b1);
        bus.in0_data = pa; bus.in0_valid = 1'b1;
        step();
        idle();
        chk("t1_issue_data", bus.issue_data, pa);
        bus.issue_ready = 1'b1;
        step();
        idle();
        step();
        chk("t1_empty_after_accept", DATA_W'(bus.empty_0), DATA_W'(1));

        // Wakeup by CDB two cycles after write.
        pa = mk_pay(5, 1'b0, 3, 1'b1);
        bus.in0_data = pa; bus.in0_valid = 1'b1;
        step();
        idle();
        step();
        bus.cdb0_valid = 1'b1; bus.cdb0_tag = TAG_W'(5);
        step();
        idle();
        chk("t2_issue_rise", DATA_W'(bus.issue_valid), DATA_W'(1));
        step();
        bus.issue_ready = 1'b1;
        step();
        idle();

        // Same-cycle write and wakeup.
        pa = mk_pay(9, 1'b0, 4, 1'b1);
        bus.in0_data = pa; bus.in0_valid = 1'b1;
        bus.cdb1_valid = 1'b1; bus.cdb1_tag = TAG_W'(9);
        step();
        idle();
        chk("t3_issue_next", DATA_W'(bus.issue_valid), DATA_W'(1));
        chk("t3_src1_rdy", DATA_W'(bus.issue_data[2*TAG_W+1]), DATA_W'(1));
        bus.issue_ready = 1'b1;
        step();
        idle();

        // Age order and stall hold.
        pa = mk_pay(10, 1'b1, 11, 1'b1);
        pb = mk_pay(12, 1'b1, 13, 1'b1);
        bus.in1_data = pa; bus.in1_valid = 1'b1;
        step();
        idle();
        bus.in0_data = pb; bus.in0_valid = 1'b1;
        step();
        idle();
        repeat (3) begin
            chk("t4_hold_e1", bus.issue_data, pa);
            step();
        end
        bus.issue_ready = 1'b1;
        step();
        chk("t4_then_e0", bus.issue_data, pb);
        step();
        idle();
        step();

        // Overflow on occupied entry, sticky until reset.
        pa = mk_pay(20, 1'b0, 21, 1'b0);
        bus.in1_data = pa; bus.in1_valid = 1'b1;
        step();
        bus.in1_data = mk_pay(22, 1'b1, 23, 1'b1);
        step();
        idle();
        chk("t5_overflow", DATA_W'(bus.overflow_err), DATA_W'(1));
        repeat (3) step();
        chk("t5_overflow_held", DATA_W'(bus.overflow_err), DATA_W'(1));
        do_reset();
        @(posedge clk); #1;
        chk("t5_overflow_cleared", DATA_W'(bus.overflow_err), DATA_W'(0));

        // Accept and write to the same entry in one cycle is an overflow.
        bus.in0_data = mk_pay(1, 1'b1, 1, 1'b1); bus.in0_valid = 1'b1;
        step();
        bus.in0_data = mk_pay(2, 1'b1, 2, 1'b1); bus.issue_ready = 1'b1;
        step();
        idle();
        step();
        do_reset();
        @(posedge clk); #1;

        // Flush with a concurrent write.
        bus.in0_data = mk_pay(30, 1'b0, 31, 1'b1); bus.in0_valid = 1'b1;
        bus.in1_data = mk_pay(32, 1'b1, 33, 1'b1); bus.in1_valid = 1'b1;
        step();
        idle();
        bus.flush = 1'b1; bus.in0_valid = 1'b1; bus.in0_data = mk_pay(1, 1'b1, 1, 1'b1);
        bus.issue_ready = 1'b1;
        step();
        idle();
        chk("t6_empty_0", DATA_W'(bus.empty_0), DATA_W'(1));
        chk("t6_empty_1", DATA_W'(bus.empty_1), DATA_W'(1));
        chk("t6_issue_valid", DATA_W'(bus.issue_valid), DATA_W'(0));
        step();

        // Asynchronous reset while an entry is presented.
        bus.in0_data = mk_pay(3, 1'b1, 4, 1'b1); bus.in0_valid = 1'b1;
        step();
        idle();
        #2 rst_n = 1'b0;
        #1 chk("async_rst_issue_valid", DATA_W'(bus.issue_valid), DATA_W'(0));
        model_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.flush       = ($urandom_range(0, 19) == 0);
            bus.in0_valid   = ($urandom_range(0, 3) == 0) && (!m_valid[0] || $urandom_range(0, 15) == 0);
            bus.in1_valid   = ($urandom_range(0, 3) == 0) && (!m_valid[1] || $urandom_range(0, 15) == 0);
            bus.in0_data    = mk_pay($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                                     $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            bus.in1_data    = mk_pay($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                                     $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            bus.cdb0_valid  = 1'($urandom_range(0, 1));
            bus.cdb0_tag    = TAG_W'($urandom_range(0, 7));
            bus.cdb1_valid  = 1'($urandom_range(0, 1));
            bus.cdb1_tag    = TAG_W'($urandom_range(0, 7));
            bus.issue_ready = ($urandom_range(0, 2) != 0);
            step();
            if (i == 300) begin
                do_reset();
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
